// File: rtl/mlp_patch_scheduler.sv
// Runs every patch of an image through the single-vector mlp: fetch, latch, launch,
// wait (with watchdog), then write the captured result out under valid/ready backpressure.
module mlp_patch_scheduler #(
    parameter int NUM_PATCHES = 16,
    parameter int HIDDEN_DIM  = 16,
    parameter int MLP_DIM     = 64,
    parameter int DATA_WIDTH  = 16,
    parameter int TIMEOUT     = 1024,
    localparam int IDX_W      = (NUM_PATCHES > 1) ? $clog2(NUM_PATCHES) : 1,
    localparam int CNT_W      = $clog2(NUM_PATCHES + 1),
    localparam int WD_W       = $clog2(TIMEOUT + 1)
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_start,
    input  logic                                  i_abort,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_err,
    output logic [CNT_W-1:0]                      o_patches_done,
    output logic                                  o_rd_en,
    output logic [IDX_W-1:0]                      o_rd_addr,
    input  logic [HIDDEN_DIM-1:0][DATA_WIDTH-1:0] i_rd_data,
    output logic                                  o_mlp_start,
    output logic                                  o_mlp_valid_in,
    output logic [HIDDEN_DIM-1:0][DATA_WIDTH-1:0] o_mlp_x,
    input  logic                                  i_mlp_done,
    input  logic [MLP_DIM-1:0][DATA_WIDTH-1:0]    i_mlp_y,
    output logic                                  o_wr_valid,
    input  logic                                  i_wr_ready,
    output logic [IDX_W-1:0]                      o_wr_addr,
    output logic [MLP_DIM-1:0][DATA_WIDTH-1:0]    o_wr_data
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_LAUNCH = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;
    localparam logic [2:0] S_FINISH = 3'd6;
    localparam logic [2:0] S_DRAIN  = 3'd7;

    logic [2:0]                            r_state;
    logic [IDX_W-1:0]                      r_idx;
    logic [CNT_W-1:0]                      r_patches_done;
    logic [WD_W-1:0]                       r_wdog;
    logic                                  r_err;
    logic [HIDDEN_DIM-1:0][DATA_WIDTH-1:0] r_mlp_x;
    logic [IDX_W-1:0]                      r_wr_addr;
    logic [MLP_DIM-1:0][DATA_WIDTH-1:0]    r_wr_data;

    logic w_timeout;
    logic w_last;

    // The watchdog fires on the TIMEOUT-th WAIT cycle, i.e. when the count is about to reach TIMEOUT.
    assign w_timeout = (r_state == S_WAIT) && (r_wdog == WD_W'(TIMEOUT - 1));
    assign w_last    = (r_idx == IDX_W'(NUM_PATCHES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_patches_done <= '0;
            r_wdog         <= '0;
            r_err          <= 1'b0;
            r_mlp_x        <= '0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state        <= S_FETCH;
                        r_idx          <= '0;
                        r_patches_done <= '0;
                        r_err          <= 1'b0;
                    end
                end
                S_FETCH: begin
                    r_state <= i_abort ? S_IDLE : S_LATCH;
                end
                S_LATCH: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_mlp_x <= i_rd_data;
                        r_state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_wdog  <= '0;
                    r_state <= i_abort ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    r_wdog <= r_wdog + 1'b1;
                    // A timeout outranks a same-cycle mlp_done, so only a clean abort+done skips the drain.
                    if (i_abort) begin
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end
                        r_state <= (i_mlp_done && !w_timeout) ? S_IDLE : S_DRAIN;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_DRAIN;
                    end else if (i_mlp_done) begin
                        r_wr_data <= i_mlp_y;
                        r_wr_addr <= r_idx;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else if (i_wr_ready) begin
                        r_patches_done <= r_patches_done + 1'b1;
                        if (w_last) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (i_mlp_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = (r_state == S_FINISH);
    assign o_err          = r_err;
    assign o_patches_done = r_patches_done;
    assign o_rd_en        = (r_state == S_FETCH);
    assign o_rd_addr      = r_idx;
    assign o_mlp_start    = (r_state == S_LAUNCH);
    assign o_mlp_valid_in = (r_state == S_LAUNCH);
    assign o_mlp_x        = r_mlp_x;
    assign o_wr_valid     = (r_state == S_WRITE);
    assign o_wr_addr      = r_wr_addr;
    assign o_wr_data      = r_wr_data;

endmodule
